// File: rtl/stream_threshold_filter.sv
// Streaming one-pixel-per-beat threshold filter: luma -> per-frame threshold -> mode select.
// Optional THRESH_STATS_EN adds hit_cnt, the hit count of the last completed output frame.
module stream_threshold_filter #(
    parameter int WIDTH = 8,
    parameter int CH    = 3,
    parameter int COLS  = 256,
    parameter int ROWS  = 256
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [WIDTH-1:0]        cfg_thr,
    input  logic [1:0]              cfg_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH*WIDTH-1:0]     in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH*WIDTH-1:0]     out_data,
    output logic                    out_last,
    output logic                    frame_done,
    output logic                    err_len,
    output logic [$clog2(ROWS)-1:0] row_cnt
`ifdef THRESH_STATS_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] hit_cnt
`endif
);
    localparam int DW = CH * WIDTH;
    localparam int RW = $clog2(ROWS);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0]    ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0]    COL_MAX = CW'(COLS - 1);
    localparam logic [WIDTH-1:0] PIX_MAX = '1;

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d, orow_q, orow_d;
    logic [WIDTH-1:0] thr_q, thr_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;

    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [DW-1:0]    s1_pix_q, s1_pix_d;
    logic [WIDTH-1:0] s1_luma_q, s1_luma_d, s1_thr_q, s1_thr_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [DW-1:0]    s2_data_q, s2_data_d;

    logic             adv, accept, frame_start, out_fire, hit;
    logic [WIDTH-1:0] luma;
    logic [DW-1:0]    filt;

    generate
        if (CH == 3) begin : g_rgb
            logic [WIDTH+1:0] sum;
            assign sum  = {2'b00, in_data[DW-1 -: WIDTH]}
                        + {1'b0, in_data[DW-WIDTH-1 -: WIDTH], 1'b0}
                        + {2'b00, in_data[WIDTH-1:0]};
            assign luma = WIDTH'(sum >> 2);
        end else begin : g_ch0
            assign luma = in_data[DW-1 -: WIDTH];
        end
    endgenerate

    always_comb begin
        hit  = (s1_luma_q >= s1_thr_q);
        filt = '0;
        for (int c = 0; c < CH; c++) begin
            case (s1_mode_q)
                2'd0:    filt[c*WIDTH +: WIDTH] = hit ? PIX_MAX : '0;
                2'd1:    filt[c*WIDTH +: WIDTH] = hit ? '0 : PIX_MAX;
                2'd2:    filt[c*WIDTH +: WIDTH] = hit ? s1_pix_q[c*WIDTH +: WIDTH] : '0;
                default: filt[c*WIDTH +: WIDTH] = hit ? s1_thr_q : s1_pix_q[c*WIDTH +: WIDTH];
            endcase
        end
    end

    always_comb begin
        adv         = !s2_valid_q || out_ready;
        accept      = in_valid && adv;
        frame_start = (row_q == '0) && (col_q == '0);
        out_fire    = s2_valid_q && out_ready;
        frame_done  = out_fire && s2_last_q && (orow_q == ROW_MAX);

        col_d = col_q;  row_d = row_q;  orow_d = orow_q;
        thr_d = thr_q;  mode_d = mode_q;  err_d = err_q;
        s1_valid_d = s1_valid_q;  s1_last_d = s1_last_q;  s1_pix_d = s1_pix_q;
        s1_luma_d  = s1_luma_q;   s1_thr_d  = s1_thr_q;   s1_mode_d = s1_mode_q;
        s2_valid_d = s2_valid_q;  s2_last_d = s2_last_q;  s2_data_d = s2_data_q;

        if (accept) begin
            if (frame_start) begin
                thr_d  = cfg_thr;
                mode_d = cfg_mode;
            end
            // A short or overlong row resyncs to column 0; only in_last advances the row.
            if (in_last) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                if (col_q != COL_MAX) err_d = 1'b1;
            end else if (col_q == COL_MAX) begin
                col_d = '0;
                err_d = 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (adv) begin
            s1_valid_d = in_valid;
            s1_pix_d   = in_data;
            s1_luma_d  = luma;
            s1_last_d  = in_last;
            s1_thr_d   = frame_start ? cfg_thr  : thr_q;
            s1_mode_d  = frame_start ? cfg_mode : mode_q;
            s2_valid_d = s1_valid_q;
            s2_data_d  = filt;
            s2_last_d  = s1_last_q;
        end

        if (out_fire && s2_last_q) orow_d = (orow_q == ROW_MAX) ? '0 : orow_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            col_q <= '0;  row_q <= '0;  orow_q <= '0;
            thr_q <= '0;  mode_q <= '0; err_q <= 1'b0;
            s1_valid_q <= 1'b0;  s1_last_q <= 1'b0;  s1_pix_q <= '0;
            s1_luma_q  <= '0;    s1_thr_q  <= '0;    s1_mode_q <= '0;
            s2_valid_q <= 1'b0;  s2_last_q <= 1'b0;  s2_data_q <= '0;
        end else begin
            col_q <= col_d;  row_q <= row_d;  orow_q <= orow_d;
            thr_q <= thr_d;  mode_q <= mode_d; err_q <= err_d;
            s1_valid_q <= s1_valid_d;  s1_last_q <= s1_last_d;  s1_pix_q <= s1_pix_d;
            s1_luma_q  <= s1_luma_d;   s1_thr_q  <= s1_thr_d;   s1_mode_q <= s1_mode_d;
            s2_valid_q <= s2_valid_d;  s2_last_q <= s2_last_d;  s2_data_q <= s2_data_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;
    assign err_len   = err_q;
    assign row_cnt   = row_q;

`ifdef THRESH_STATS_EN
    localparam int HW = $clog2(ROWS*COLS+1);
    logic          s2_hit_q, s2_hit_d;
    logic [HW-1:0] run_q, run_d, hit_cnt_q, hit_cnt_d;

    // Counting is on the output side so frame boundaries follow frame_done, not input.
    always_comb begin
        s2_hit_d  = adv ? hit : s2_hit_q;
        run_d     = run_q;
        hit_cnt_d = hit_cnt_q;
        if (out_fire) begin
            if (frame_done) begin
                hit_cnt_d = run_q + HW'(s2_hit_q);
                run_d     = '0;
            end else begin
                run_d     = run_q + HW'(s2_hit_q);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_hit_q <= 1'b0;  run_q <= '0;  hit_cnt_q <= '0;
        end else begin
            s2_hit_q <= s2_hit_d;  run_q <= run_d;  hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`endif
endmodule

// File: tb/tb_stream_threshold_filter.sv
// Bench for stream_threshold_filter on a small frame: vector table plus scoreboard-checked
// sequences for latency, stalls, mid-frame cfg, length error, reset and optional stats.
module tb_stream_threshold_filter;
    localparam int W = 8, CH = 3, COLS = 4, ROWS = 3, NPIX = COLS * ROWS, DW = CH * W;

    logic CLK = 1'b0, RST;
    logic [W-1:0] cfg_thr;
    logic [1:0] cfg_mode;
    logic in_valid, in_ready, in_last, out_valid, out_ready, out_last, frame_done, err_len;
    logic [DW-1:0] in_data, out_data;
    logic [$clog2(ROWS)-1:0] row_cnt;
`ifdef THRESH_STATS_EN
    logic [$clog2(NPIX+1)-1:0] hit_cnt;
`endif

    stream_threshold_filter #(.WIDTH(W), .CH(CH), .COLS(COLS), .ROWS(ROWS)) dut (
        .CLK(CLK), .RST(RST), .cfg_thr(cfg_thr), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_done(frame_done), .err_len(err_len), .row_cnt(row_cnt)
`ifdef THRESH_STATS_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
    typedef struct { logic [1:0] mode; logic [7:0] thr; logic [DW-1:0] pix; logic [DW-1:0] res; } vec_t;

    exp_t q[$];
    vec_t vecs[12];
    int checks = 0, errors = 0;
    int m_col = 0, m_row = 0, orow = 0, out_cnt = 0, fd_cnt = 0;
    logic [7:0] m_thr = 0;
    logic [1:0] m_mode = 0;
    logic rnd_rdy = 1'b0, rdy_force = 1'b1;
    logic stall_p = 1'b0, last_p = 1'b0;
    logic [DW-1:0] data_p = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] p, input logic [7:0] t,
                                            input logic [1:0] m);
        int l;
        bit h;
        l = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
        h = (l >= int'(t));
        case (m)
            2'd0:    return h ? 24'hFFFFFF : 24'h000000;
            2'd1:    return h ? 24'h000000 : 24'hFFFFFF;
            2'd2:    return h ? p : 24'h000000;
            default: return h ? {t, t, t} : p;
        endcase
    endfunction

    always @(posedge CLK) begin
        #1;
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Output monitor: scoreboard pop, stall stability, frame_done placement.
    always @(negedge CLK) begin
        if (RST) begin
            orow = 0;
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(data_p));
                chk("hold_last", 32'(out_last), 32'(last_p));
            end
            chk("frame_done", 32'(frame_done),
                32'(out_valid && out_ready && out_last && orow == ROWS - 1));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_data), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_last", 32'(out_last), 32'(e.l));
                end
                out_cnt++;
                if (frame_done) fd_cnt++;
                if (out_last) orow = (orow == ROWS - 1) ? 0 : orow + 1;
            end
            stall_p = out_valid && !out_ready;
            data_p  = out_data;
            last_p  = out_last;
        end
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        q.delete();
        m_col = 0; m_row = 0; m_thr = 0; m_mode = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [DW-1:0] pix, input logic last, input logic use_exp,
                        input logic [DW-1:0] exp_d);
        int n;
        logic ok;
        exp_t e;
        in_valid = 1'b1; in_data = pix; in_last = last;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 1000) begin
            @(negedge CLK);
            ok = in_ready;
            if (!ok) begin @(posedge CLK); #1; end
            n++;
        end
        if (!ok) begin
            chk("accept_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
            return;
        end
        if (m_row == 0 && m_col == 0) begin m_thr = cfg_thr; m_mode = cfg_mode; end
        e.d = use_exp ? exp_d : model(pix, m_thr, m_mode);
        e.l = last;
        q.push_back(e);
        if (last) begin
            m_col = 0;
            m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end else if (m_col == COLS - 1) m_col = 0;
        else m_col++;
        @(posedge CLK); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin @(posedge CLK); n++; end
        @(posedge CLK); #1;
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int oc0, fd0;
        in_valid = 0; in_data = 0; in_last = 0; cfg_thr = 0; cfg_mode = 0; RST = 1'b1;
        vecs[0]  = '{2'd0, 8'h80, 24'hC89664, 24'hFFFFFF};
        vecs[1]  = '{2'd0, 8'h80, 24'h0A141E, 24'h000000};
        vecs[2]  = '{2'd3, 8'h40, 24'h808080, 24'h404040};
        vecs[3]  = '{2'd3, 8'h40, 24'h101010, 24'h101010};
        vecs[4]  = '{2'd1, 8'h80, 24'hC89664, 24'h000000};
        vecs[5]  = '{2'd1, 8'h80, 24'h0A141E, 24'hFFFFFF};
        vecs[6]  = '{2'd2, 8'h50, 24'h605040, 24'h605040};
        vecs[7]  = '{2'd2, 8'h51, 24'h605040, 24'h000000};
        vecs[8]  = '{2'd0, 8'h00, 24'h000000, 24'hFFFFFF};
        vecs[9]  = '{2'd3, 8'hFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[10] = '{2'd3, 8'hFF, 24'hFFFFFE, 24'hFFFFFE};
        vecs[11] = '{2'd0, 8'h80, 24'h00FF02, 24'hFFFFFF};

        do_reset();
        @(negedge CLK);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_err_len", 32'(err_len), 0);
        chk("rst_row_cnt", 32'(row_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        step();

        // Two-cycle latency on the first pixel of a frame.
        cfg_mode = 2'd0; cfg_thr = 8'd128;
        send(24'hC89664, 1'b0, 1'b1, 24'hFFFFFF);
        @(negedge CLK); chk("lat_cycle1_valid", 32'(out_valid), 0);
        @(negedge CLK); chk("lat_cycle2_valid", 32'(out_valid), 1);
        chk("lat_cycle2_data", 32'(out_data), 32'hFFFFFF);
        step();
        for (int i = 1; i < NPIX; i++) send(24'h0A141E, 1'(i % COLS == COLS - 1), 1'b1, 24'h000000);
        drain();

        // One full frame per table vector, full rate.
        for (int v = 0; v < 12; v++) begin
            cfg_mode = vecs[v].mode; cfg_thr = vecs[v].thr;
            for (int i = 0; i < NPIX; i++)
                send(vecs[v].pix, 1'(i % COLS == COLS - 1), 1'b1, vecs[v].res);
        end
        drain();

        // Random stalls, cfg changed mid-frame: frame 1 keeps 0x80, frame 2 uses 0x10.
        oc0 = out_cnt; fd0 = fd_cnt;
        rnd_rdy = 1'b1;
        cfg_mode = 2'd2; cfg_thr = 8'h80;
        for (int i = 0; i < NPIX; i++) begin
            if (i == 5) cfg_thr = 8'h10;
            if (i == 8) send(24'h404040, 1'(i % COLS == COLS - 1), 1'b1, 24'h000000);
            else send(24'($urandom), 1'(i % COLS == COLS - 1), 1'b0, '0);
        end
        for (int i = 0; i < NPIX; i++) begin
            if (i == 8) send(24'h404040, 1'(i % COLS == COLS - 1), 1'b1, 24'h404040);
            else send(24'($urandom), 1'(i % COLS == COLS - 1), 1'b0, '0);
        end
        rnd_rdy = 1'b0;
        drain();
        chk("stall_out_count", 32'(out_cnt - oc0), 32'(2 * NPIX));
        chk("stall_frame_done_count", 32'(fd_cnt - fd0), 32'd2);

        // Short last row: error is sticky, row wraps, next beat is a fresh frame start.
        cfg_mode = 2'd0; cfg_thr = 8'h80;
        for (int i = 0; i < (ROWS - 1) * COLS; i++)
            send(24'($urandom), 1'(i % COLS == COLS - 1), 1'b0, '0);
        chk("err_before", 32'(err_len), 0);
        send(24'h808080, 1'b0, 1'b0, '0);
        send(24'h808080, 1'b1, 1'b0, '0);
        chk("err_set", 32'(err_len), 1);
        chk("err_row_wrap", 32'(row_cnt), 0);
        cfg_mode = 2'd1;
        for (int i = 0; i < NPIX; i++) send(24'hFFFFFF, 1'(i % COLS == COLS - 1), 1'b1, 24'h000000);
        drain();
        chk("err_sticky", 32'(err_len), 1);
        chk("err_row_after", 32'(row_cnt), 0);

        // Reset with two pixels stuck in the pipe.
        cfg_mode = 2'd0;
        for (int i = 0; i < COLS; i++) send(24'hFFFFFF, 1'(i == COLS - 1), 1'b0, '0);
        drain();
        chk("pre_rst_row", 32'(row_cnt), 1);
        rdy_force = 1'b0;
        step();
        send(24'hFFFFFF, 1'b0, 1'b0, '0);
        send(24'hFFFFFF, 1'b0, 1'b0, '0);
        chk("inflight_held", 32'(out_valid), 1);
        RST = 1'b1;
        q.delete();
        m_col = 0; m_row = 0;
        step();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_row_cnt", 32'(row_cnt), 0);
        chk("midrst_err_len", 32'(err_len), 0);
        step();
        RST = 1'b0;
        rdy_force = 1'b1;
        repeat (6) step();
        chk("midrst_no_output", 32'(out_valid), 0);

`ifdef THRESH_STATS_EN
        cfg_mode = 2'd0; cfg_thr = 8'h80;
        for (int i = 0; i < NPIX; i++) send(24'hFFFFFF, 1'(i % COLS == COLS - 1), 1'b0, '0);
        drain();
        chk("hit_cnt_white", 32'(hit_cnt), 32'(NPIX));
        for (int i = 0; i < NPIX; i++)
            send((i % 2 == 0) ? 24'hFFFFFF : 24'h000000, 1'(i % COLS == COLS - 1), 1'b0, '0);
        drain();
        chk("hit_cnt_half", 32'(hit_cnt), 32'(NPIX / 2));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
